// File: rtl/adder_pkg.sv
// Shared types for the adder response unit: result entry layout, stats width,
// and the buffer occupancy states.
package adder_pkg;

  localparam int OVF_CNT_W   = 16;
  // Widest operand the shared entry type can carry; WIDTH must not exceed it.
  localparam int ADDER_MAX_W = 32;

  typedef struct packed {
    logic [ADDER_MAX_W-1:0] sum;
    logic                   cout;
  } adder_rsp_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_e;

endpackage

// File: rtl/adder_rsp_fifo.sv
// Result buffer for adder_rsp_unit: circular store with an EMPTY/PARTIAL/FULL
// occupancy FSM. The state output is the single source of full/empty.
module adder_rsp_fifo
  import adder_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = adder_rsp_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  entry_t     wdata,
  input  logic       pop,
  output entry_t     rdata,
  output occ_state_e state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  count_d;
  occ_state_e     state_q;
  occ_state_e     state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OCC_EMPTY;
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= wdata;
  end

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (count_d == '0)
      state_d = OCC_EMPTY;
    else if (count_d == CW'(DEPTH))
      state_d = OCC_FULL;
    else
      state_d = OCC_PARTIAL;
  end

  assign state = state_q;
  assign rdata = (state_q == OCC_EMPTY) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/adder_rsp_unit.sv
// Buffered adder: accepts operand sets, returns {cout,sum} in acceptance order.
// Optional overflow statistics port enabled by ADDER_RSP_STATS_EN.
module adder_rsp_unit
  import adder_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  input  logic                 req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_sum,
  output logic                 rsp_cout
`ifdef ADDER_RSP_STATS_EN
  ,
  output logic [OVF_CNT_W-1:0] ovf_count
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // req_ready and rsp_valid come from registered occupancy only, so neither
  // depends combinationally on the other side's valid or ready.

  logic [WIDTH:0] total;
  adder_rsp_t     wentry;
  adder_rsp_t     rentry;
  occ_state_e     occ_state;
  logic           push;
  logic           pop;

  assign total = {1'b0, req_a} + {1'b0, req_b} + {{WIDTH{1'b0}}, req_cin};

  always_comb begin
    wentry                  = '0;
    wentry.sum[WIDTH-1:0]   = total[WIDTH-1:0];
    wentry.cout             = total[WIDTH];
  end

  assign req_ready = (occ_state != OCC_FULL);
  assign rsp_valid = (occ_state != OCC_EMPTY);
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  adder_rsp_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (adder_rsp_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (rentry),
    .state (occ_state)
  );

  // The buffer returns zeros when empty, so the outputs need no extra gating.
  assign rsp_sum  = rentry.sum[WIDTH-1:0];
  assign rsp_cout = rentry.cout;

  generate
    if (WIDTH < ADDER_MAX_W) begin : g_hi
      logic unused_sum_hi;
      assign unused_sum_hi = |rentry.sum[ADDER_MAX_W-1:WIDTH];
    end
  endgenerate

`ifdef ADDER_RSP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      ovf_count <= '0;
    else if (push && total[WIDTH] && (ovf_count != {OVF_CNT_W{1'b1}}))
      ovf_count <= ovf_count + OVF_CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_adder_rsp_unit.sv
// Self-checking bench for adder_rsp_unit: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_adder_rsp_unit;

  localparam int W     = 2;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_cin;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
`ifdef ADDER_RSP_STATS_EN
  logic [15:0]  ovf_count;
`endif

  adder_rsp_unit #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
`ifdef ADDER_RSP_STATS_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: expected {cout,sum} in acceptance order, plus overflow count.
  logic [W:0] exp_q[$];
  int         exp_ovf;
  int         n_cmp;
  int         n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    int s;
    s = int'(a) + int'(b) + int'(c);
    return s[W:0];
  endfunction

  task automatic check_outputs();
    logic [W:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("req_ready", 32'(req_ready), 32'(exp_q.size() < DEPTH));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
    check("rsp_sum",   32'(rsp_sum),   32'(head[W-1:0]));
    check("rsp_cout",  32'(rsp_cout),  32'(head[W]));
`ifdef ADDER_RSP_STATS_EN
    check("ovf_count", 32'(ovf_count), 32'(exp_ovf));
`endif
  endtask

  // One clock: called at a negedge, drives, checks, advances model, returns at next negedge.
  task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic rr, output logic acc);
    logic       pp;
    logic [W:0] r;
    req_valid = v; req_a = a; req_b = b; req_cin = c; rsp_ready = rr;
    check_outputs();
    acc = v && (exp_q.size() < DEPTH);
    pp  = rr && (exp_q.size() != 0);
    r   = ref_add(a, b, c);
    @(posedge clk);
    if (pp)  void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(r);
      if (r[W] && exp_ovf < 65535) exp_ovf++;
    end
    @(negedge clk);
  endtask

  task automatic rand_cycle(input int pv, input int pr);
    logic acc;
    cycle(($urandom_range(0, 99) < pv), W'($urandom), W'($urandom), 1'($urandom),
          ($urandom_range(0, 99) < pr), acc);
  endtask

  // Reset with a handshake offered in the same cycle; it must be ignored.
  task automatic pulse_reset();
    rst = 1'b1; req_valid = 1'b1; req_a = W'($urandom); req_b = W'($urandom);
    req_cin = 1'b1; rsp_ready = 1'b1;
    @(posedge clk);
    exp_q.delete();
    exp_ovf = 0;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
  endtask

  initial begin
    logic       acc;
    logic [W-1:0] held_sum;
    logic         held_cout;
    int           n_acc;
    logic         fifth_done;

    n_cmp = 0; n_err = 0; exp_ovf = 0;
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_cin = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_sum",   32'(rsp_sum),   32'd0);
    check("rst_rsp_cout",  32'(rsp_cout),  32'd0);

    // 01 + 10 + 0 = 011.
    cycle(1'b1, 2'b01, 2'b10, 1'b0, 1'b1, acc);
    check("t1_valid", 32'(rsp_valid), 32'd1);
    check("t1_sum",   32'(rsp_sum),   32'd3);
    check("t1_cout",  32'(rsp_cout),  32'd0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);

    // 11 + 01 + 1 = 101.
    cycle(1'b1, 2'b11, 2'b01, 1'b1, 1'b1, acc);
    check("t2_sum",  32'(rsp_sum),  32'd1);
    check("t2_cout", 32'(rsp_cout), 32'd1);
`ifdef ADDER_RSP_STATS_EN
    check("t2_ovf",  32'(ovf_count), 32'd1);
`endif
    cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);

    // Fill with consumer stalled: 5 requests, only 4 fit.
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, W'(i), W'(i + 1), 1'(i), 1'b0, acc);
      if (acc) n_acc++;
    end
    check("fill_accepts", 32'(n_acc), 32'd4);
    check("fill_ready",   32'(req_ready), 32'd0);
    held_sum = rsp_sum; held_cout = rsp_cout;
    cycle(1'b1, 2'd3, 2'd2, 1'b1, 1'b0, acc);
    check("hold_sum",  32'(rsp_sum),  32'(held_sum));
    check("hold_cout", 32'(rsp_cout), 32'(held_cout));
    fifth_done = 1'b0;
    for (int i = 0; i < 10 && !fifth_done; i++) begin
      cycle(1'b1, 2'd3, 2'd2, 1'b1, 1'b1, acc);
      fifth_done = acc;
    end
    check("fifth_accepted", 32'(fifth_done), 32'd1);
    repeat (6) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);

    // Hold occupancy at 2 with simultaneous push/pop across pointer wrap.
    repeat (2) cycle(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0, acc);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1, acc);
      check("steady_valid", 32'(rsp_valid), 32'd1);
    end
    check("steady_depth", 32'(exp_q.size()), 32'd2);
    repeat (3) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);

    // Reset with 3 entries buffered; none of them may reappear.
    repeat (3) cycle(1'b1, 2'd3, 2'd3, 1'b1, 1'b0, acc);
    pulse_reset();
    check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mrst_req_ready", 32'(req_ready), 32'd1);
    check("mrst_rsp_sum",   32'(rsp_sum),   32'd0);
`ifdef ADDER_RSP_STATS_EN
    check("mrst_ovf",       32'(ovf_count), 32'd0);
`endif
    repeat (3) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);

    // Random traffic with varying pressure.
    for (int i = 0; i < 300; i++) rand_cycle(70, 40);
    for (int i = 0; i < 300; i++) rand_cycle(40, 80);
    for (int i = 0; i < 10; i++)  rand_cycle(0, 100);

`ifdef ADDER_RSP_STATS_EN
    // Overflow counter saturation.
    for (int i = 0; i < 65540; i++) cycle(1'b1, 2'd3, 2'd3, 1'b1, 1'b1, acc);
    check("ovf_saturated", 32'(ovf_count), 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
